// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Optional status outputs (count, overflow, underflow) are enabled by defining FIFO_SYNC_STATUS_EN.
module fifo_sync #(
    parameter int DATA_WIDTH = 5,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wen,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_SYNC_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty  = (wptr == rptr);
    assign full   = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                    (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    assign rd_acc = ren & ~empty;
    assign wr_acc = wen & (~full | rd_acc);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + PTR_ONE;
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
                dout <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_acc)
            mem[wptr[ADDR_WIDTH-1:0]] <= din;
    end

`ifdef FIFO_SYNC_STATUS_EN
    assign count = wptr - rptr;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wen & full & ~rd_acc;
            underflow <= ren & empty;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync; status outputs are checked when FIFO_SYNC_STATUS_EN is defined.
module tb_fifo_sync;

    logic       clock;
    logic       rst;
    logic [4:0] din;
    logic       wen;
    logic       ren;
    logic [4:0] dout;
    logic       full;
    logic       empty;
`ifdef FIFO_SYNC_STATUS_EN
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fifo_sync dut (
        .clock (clock),
        .rst   (rst),
        .din   (din),
        .wen   (wen),
        .ren   (ren),
        .dout  (dout),
        .full  (full),
        .empty (empty)
`ifdef FIFO_SYNC_STATUS_EN
        ,
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(negedge clock);
    endtask

    logic [4:0] seq5 [5] = '{5'h04, 5'h01, 5'h09, 5'h03, 5'h0D};
    logic [4:0] prev;

    initial begin
        rst = 1'b0; din = '0; wen = 1'b0; ren = 1'b0;
        #2;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_dout",  32'(dout),  32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Five words through
        for (int i = 0; i < 5; i++) begin
            wen = 1'b1; din = seq5[i];
            cyc();
            check("seq_wr_empty", 32'(empty), 32'd0);
        end
        wen = 1'b0;
`ifdef FIFO_SYNC_STATUS_EN
        check("seq_count", 32'(count), 32'd5);
`endif
        for (int i = 0; i < 5; i++) begin
            ren = 1'b1;
            cyc();
            check("seq_rd_dout", 32'(dout), 32'(seq5[i]));
            check("seq_rd_full", 32'(full), 32'd0);
        end
        ren = 1'b0;
        check("seq_end_empty", 32'(empty), 32'd1);

        // Fill with nine words, the ninth must drop
        for (int i = 0; i < 9; i++) begin
            wen = 1'b1; din = 5'(5'h10 + i);
            cyc();
            check("fill_full", 32'(full), (i >= 7) ? 32'd1 : 32'd0);
`ifdef FIFO_SYNC_STATUS_EN
            check("fill_overflow", 32'(overflow), (i == 8) ? 32'd1 : 32'd0);
`endif
        end
        wen = 1'b0;
        cyc();
`ifdef FIFO_SYNC_STATUS_EN
        check("fill_count", 32'(count), 32'd8);
        check("fill_overflow_clr", 32'(overflow), 32'd0);
`endif

        // Simultaneous write and read while full
        wen = 1'b1; ren = 1'b1; din = 5'h1F;
        cyc();
        wen = 1'b0; ren = 1'b0;
        check("full_wr_rd_dout", 32'(dout), 32'h10);
        check("full_wr_rd_full", 32'(full), 32'd1);

        // Drain: 0x11..0x17 then 0x1F
        for (int i = 0; i < 8; i++) begin
            ren = 1'b1;
            cyc();
            check("drain_dout", 32'(dout), (i == 7) ? 32'h1F : 32'(5'h11 + i));
            check("drain_full", 32'(full), 32'd0);
        end
        ren = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Reads on empty FIFO
        for (int i = 0; i < 3; i++) begin
            ren = 1'b1;
            cyc();
            check("uf_dout",  32'(dout),  32'h1F);
            check("uf_empty", 32'(empty), 32'd1);
`ifdef FIFO_SYNC_STATUS_EN
            check("uf_pulse", 32'(underflow), 32'd1);
            check("uf_count", 32'(count), 32'd0);
`endif
        end
        ren = 1'b0;
        cyc();
`ifdef FIFO_SYNC_STATUS_EN
        check("uf_pulse_clr", 32'(underflow), 32'd0);
`endif

        // Simultaneous on empty: write only
        wen = 1'b1; ren = 1'b1; din = 5'h0A;
        cyc();
        wen = 1'b0; ren = 1'b0;
        check("empty_wr_rd_dout",  32'(dout),  32'h1F);
        check("empty_wr_rd_empty", 32'(empty), 32'd0);
        ren = 1'b1;
        cyc();
        ren = 1'b0;
        check("empty_wr_rd_data",  32'(dout),  32'h0A);
        check("empty_wr_rd_empty2", 32'(empty), 32'd1);

        // Wrap-around with one entry in flight
        wen = 1'b1; din = 5'h03;
        cyc();
        prev = 5'h03;
        for (int i = 0; i < 20; i++) begin
            wen = 1'b1; ren = 1'b1; din = 5'((i * 7 + 5) % 32);
            cyc();
            check("wrap_dout", 32'(dout), 32'(prev));
            check("wrap_empty", 32'(empty), 32'd0);
`ifdef FIFO_SYNC_STATUS_EN
            check("wrap_count", 32'(count), 32'd1);
`endif
            prev = din;
        end
        wen = 1'b0; ren = 1'b1;
        cyc();
        ren = 1'b0;
        check("wrap_last", 32'(dout), 32'(prev));
        check("wrap_empty_end", 32'(empty), 32'd1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; din = 5'(5'h15 + i);
            cyc();
        end
        wen = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_full",  32'(full),  32'd0);
        check("async_rst_dout",  32'(dout),  32'd0);
`ifdef FIFO_SYNC_STATUS_EN
        check("async_rst_count", 32'(count), 32'd0);
`endif
        cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
